ex_operand_stage: RTL
=====================

# ex_operand_stage

Execute-stage operand register for the 3-stage RISC-V core, sitting directly upstream of the ALU. It captures decoded instruction fields at the ID/EX boundary and resolves RAW hazards by forwarding from the executing instruction and from writeback. It selects and registers the ALU A/B operands, ALU control and funct7, and raises a load-use interlock toward decode.

## Interface
- XLEN, 32, datapath width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode slot holds a real instruction
- id_rs1_addr, id_rs2_addr  in  5  source register indices
- id_rs1_data, id_rs2_data  in  XLEN  regfile read data
- id_pc, id_imm  in  XLEN  instruction PC; sign-extended immediate
- id_a_sel  in  2  A source: 0 = rs1, 1 = pc, 2 = zero (LUI), 3 = reserved, treated as zero
- id_b_sel  in  1  B source: 0 = rs2, 1 = imm
- id_alu_ctl  in  5  ALU operation code
- id_funct7  in  7  funct7, bit 5 selects SRA vs SRL
- id_rd_addr  in  5  destination index
- id_reg_wen, id_is_load  in  1  writes rd; is a load
- ex_alu_result  in  XLEN  current ALU output, for EX→ID forwarding
- wb_wen  in  1  writeback writes this cycle
- wb_rd_addr  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- stall  in  1  hold all registered state
- flush  in  1  squash the instruction entering EX
- ex_valid  out  1  registered valid
- alu_a, alu_b  out  XLEN  registered ALU operands
- alu_ctl  out  5  registered ALU operation code
- alu_funct7  out  7  registered funct7
- ex_store_data  out  XLEN  forwarded rs2 value, registered
- ex_rd_addr  out  5  registered destination index
- ex_reg_wen, ex_is_load  out  1  registered controls
- hazard_stall  out  1  combinational load-use interlock

## Operation
- Forwarding is resolved independently for rs1 and rs2. Candidate value in priority order:
  - (1) EX hit: ex_valid & ex_reg_wen & !ex_is_load & ex_rd_addr==src & src!=0 → ex_alu_result
  - (2) WB hit: wb_wen & wb_rd_addr==src & src!=0 → wb_data
  - (3) otherwise → id_rsX_data
- Source index 0 always yields 0, whatever the regfile data or forwarding matches.
- A operand = forwarded rs1, id_pc or 0 per id_a_sel. B operand = forwarded rs2 or id_imm per id_b_sel. ex_store_data = forwarded rs2, regardless of id_b_sel.
- hazard_stall = id_valid & ex_valid & ex_is_load & ex_rd_addr!=0 & (ex_rd_addr==id_rs1_addr | ex_rd_addr==id_rs2_addr).
  - Asserted on a match even when the field is unused (e.g. rs2 on I-type); this is conservative and accepted.
  - While hazard_stall is high, the stage inserts a bubble: next ex_valid=0, ex_reg_wen=0, ex_is_load=0. Decode holds, and the EX load advances to WB.
- Register update per rising edge, in priority order:
  - flush: ex_valid, ex_reg_wen, ex_is_load ← 0. Data fields are don't-care and may load.
  - stall: all registers hold.
  - hazard_stall: bubble as above.
  - else: capture all id_* derived values; ex_valid ← id_valid.
- ex_reg_wen and ex_is_load are gated by id_valid on capture: an invalid slot never writes.

## Timing
- Reset (rst_n low, asynchronous): every registered output is 0, i.e. ex_valid=0, alu_a=alu_b=0, alu_ctl=0, alu_funct7=0, ex_store_data=0, ex_rd_addr=0, ex_reg_wen=0, ex_is_load=0.
- hazard_stall is 0 while in reset, because ex_valid=0.
- Reset deassertion is asynchronous in effect. The first capture occurs at the first rising edge with rst_n high.
- Latency is 1 cycle from id_* to the registered outputs. Forwarding muxes are combinational ahead of the flops.
- flush and stall asserted together: flush wins and the EX slot becomes a bubble.
- stall and hazard_stall together: stall wins and the state holds. hazard_stall is re-evaluated next cycle.
- Back-to-back dependent ALU ops need no bubble, via EX forwarding. A load followed by a dependent op costs exactly 1 bubble; the value then arrives via WB forwarding.
- EX and WB both matching the same source: the EX value is used, as the younger producer.

## Test plan
- Reset: drive rst_n low mid-run with ex_valid=1 → all outputs 0 immediately, without waiting for a clock edge; release, apply id_valid=1 ADD with rs1=5 (regfile 7) and imm=3 (b_sel=1) → next edge alu_a=7, alu_b=3, ex_valid=1.
- EX forwarding: issue `addi x1,x0,10`, then `add x2,x1,x1` with stale regfile x1=0 and ex_alu_result=10 → alu_a=alu_b=10 for the second instruction, hazard_stall=0.
- WB forwarding and priority: wb writes x3=0x55 while EX targets x3 with ex_alu_result=0x99; ID reads x3 → alu_a=0x99. Repeat with EX targeting x4 → alu_a=0x55.
- x0 guard: wb_wen=1, wb_rd_addr=0, wb_data=0xFFFF_FFFF; ID reads rs1=0 with regfile data 0x1234 → alu_a=0.
- Load-use: EX holds a load to x6; ID `sub x7,x6,x2` → hazard_stall=1, next edge ex_valid=0 and ex_reg_wen=0; the following cycle, with wb_data=0x40 for x6 and x2=0x10, the sub captures alu_a=0x40, alu_b=0x10, alu_ctl=SUB.
- Stall/flush: with stall=1 for 3 cycles, the outputs hold and id_* changes are ignored; then assert flush and stall together → next edge ex_valid=0.

Source files
------------

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX operand register with RAW forwarding and load-use interlock
//
// Purpose: registers the decoded instruction into the execute slot, resolving
// rs1/rs2 against the executing instruction (EX) and the writeback port (WB),
// selecting the ALU A/B operands, and flagging a load-use hazard to decode.
//
// Ports:
//   clk_i, rst_ni               clock (rising edge), asynchronous active-low reset
//   id_*_i                      decoded instruction fields from the decode slot
//   ex_alu_result_i             current ALU output, forwarded from EX
//   wb_wen_i/wb_rd_addr_i/wb_data_i  writeback port, forwarded from WB
//   stall_i, flush_i            hold / squash the EX slot
//   ex_valid_o .. ex_is_load_o  registered execute-slot contents
//   hazard_stall_o              combinational load-use interlock toward decode

module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            id_valid_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [1:0]      id_a_sel_i,
  input  logic            id_b_sel_i,
  input  logic [4:0]      id_alu_ctl_i,
  input  logic [6:0]      id_funct7_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_reg_wen_i,
  input  logic            id_is_load_i,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic            wb_wen_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [4:0]      alu_ctl_o,
  output logic [6:0]      alu_funct7_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic            ex_reg_wen_o,
  output logic            ex_is_load_o,
  output logic            hazard_stall_o
);

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [4:0]      alu_ctl_q, alu_ctl_d;
  logic [6:0]      alu_funct7_q, alu_funct7_d;
  logic [XLEN-1:0] store_data_q, store_data_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic            reg_wen_q, reg_wen_d;
  logic            is_load_q, is_load_d;

  logic            ex_fwd_ok;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] op_a, op_b;
  logic            hazard;

  // A load's result is not available in EX, so it never forwards from there;
  // that case is covered by the interlock plus WB forwarding one cycle later.
  assign ex_fwd_ok = ex_valid_q & reg_wen_q & ~is_load_q;

  always_comb begin
    rs1_fwd = id_rs1_data_i;
    if (id_rs1_addr_i == 5'd0) begin
      rs1_fwd = '0;
    end else if (ex_fwd_ok && (rd_addr_q == id_rs1_addr_i)) begin
      rs1_fwd = ex_alu_result_i;
    end else if (wb_wen_i && (wb_rd_addr_i == id_rs1_addr_i)) begin
      rs1_fwd = wb_data_i;
    end
  end

  always_comb begin
    rs2_fwd = id_rs2_data_i;
    if (id_rs2_addr_i == 5'd0) begin
      rs2_fwd = '0;
    end else if (ex_fwd_ok && (rd_addr_q == id_rs2_addr_i)) begin
      rs2_fwd = ex_alu_result_i;
    end else if (wb_wen_i && (wb_rd_addr_i == id_rs2_addr_i)) begin
      rs2_fwd = wb_data_i;
    end
  end

  always_comb begin
    unique case (id_a_sel_i)
      2'd0:    op_a = rs1_fwd;
      2'd1:    op_a = id_pc_i;
      default: op_a = '0;
    endcase
    op_b = id_b_sel_i ? id_imm_i : rs2_fwd;
  end

  // Matches on rs2 even for formats that ignore it; a spare bubble is harmless.
  assign hazard = id_valid_i & ex_valid_q & is_load_q & (rd_addr_q != 5'd0) &
                  ((rd_addr_q == id_rs1_addr_i) | (rd_addr_q == id_rs2_addr_i));
  assign hazard_stall_o = hazard;

  always_comb begin
    ex_valid_d   = ex_valid_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctl_d    = alu_ctl_q;
    alu_funct7_d = alu_funct7_q;
    store_data_d = store_data_q;
    rd_addr_d    = rd_addr_q;
    reg_wen_d    = reg_wen_q;
    is_load_d    = is_load_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
      reg_wen_d  = 1'b0;
      is_load_d  = 1'b0;
    end else if (stall_i) begin
      // hold everything
    end else if (hazard) begin
      ex_valid_d = 1'b0;
      reg_wen_d  = 1'b0;
      is_load_d  = 1'b0;
    end else begin
      ex_valid_d   = id_valid_i;
      alu_a_d      = op_a;
      alu_b_d      = op_b;
      alu_ctl_d    = id_alu_ctl_i;
      alu_funct7_d = id_funct7_i;
      store_data_d = rs2_fwd;
      rd_addr_d    = id_rd_addr_i;
      reg_wen_d    = id_valid_i & id_reg_wen_i;
      is_load_d    = id_valid_i & id_is_load_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ex_valid_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctl_q    <= '0;
      alu_funct7_q <= '0;
      store_data_q <= '0;
      rd_addr_q    <= '0;
      reg_wen_q    <= 1'b0;
      is_load_q    <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctl_q    <= alu_ctl_d;
      alu_funct7_q <= alu_funct7_d;
      store_data_q <= store_data_d;
      rd_addr_q    <= rd_addr_d;
      reg_wen_q    <= reg_wen_d;
      is_load_q    <= is_load_d;
    end
  end

  assign ex_valid_o      = ex_valid_q;
  assign alu_a_o         = alu_a_q;
  assign alu_b_o         = alu_b_q;
  assign alu_ctl_o       = alu_ctl_q;
  assign alu_funct7_o    = alu_funct7_q;
  assign ex_store_data_o = store_data_q;
  assign ex_rd_addr_o    = rd_addr_q;
  assign ex_reg_wen_o    = reg_wen_q;
  assign ex_is_load_o    = is_load_q;

endmodule
